// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: PC control, instruction ROM port, redirect input and decode handshake.
// The master modport is the fetch unit; slave is the surrounding CPU/ROM/decoder.
interface fetch_unit_if #(
    parameter int INSTR_W = 16
);
    logic [15:0]        pc_in;
    logic               pc_load;
    logic [15:0]        pc_new;
    logic [15:0]        rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               redirect_valid;
    logic [15:0]        redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic [15:0]        instr_pc;

    modport master (
        input  pc_in, rom_data, redirect_valid, redirect_pc, instr_ready,
        output pc_load, pc_new, rom_addr, instr_valid, instr_data, instr_pc
    );

    modport slave (
        output pc_in, rom_data, redirect_valid, redirect_pc, instr_ready,
        input  pc_load, pc_new, rom_addr, instr_valid, instr_data, instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// MAK-8 instruction fetch front-end: drives the PC, fetches from a synchronous ROM, buffers words
// in a DEPTH-entry prefetch queue. Define FETCH_BYPASS_EN to forward a returning word straight to decode.
module fetch_unit #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 16
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [15:0]        pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t             mem_reg [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               inflight_reg;
    logic [15:0]        inflight_pc_reg;

    logic [CNT_W:0]     occupancy;
    logic               stall;
    logic               issue;
    logic               q_valid;
    logic               arrival;
    logic               bypass;
    logic               push;
    logic               pop;
    logic [DEPTH-1:0]   wr_en;
    entry_t             head;

    // The in-flight word already owns a slot, so it counts toward fullness.
    assign occupancy = (CNT_W + 1)'(count_reg) + (CNT_W + 1)'(inflight_reg);
    assign stall     = occupancy >= (CNT_W + 1)'(DEPTH);
    assign issue     = !stall && !bus.redirect_valid;
    assign q_valid   = count_reg != '0;
    assign arrival   = inflight_reg && !bus.redirect_valid;
    assign head      = mem_reg[rd_ptr_reg];

`ifdef FETCH_BYPASS_EN
    assign bypass = arrival && !q_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push     = arrival && !(bypass && bus.instr_ready);
    assign pop      = q_valid && bus.instr_ready;
    assign bus.rom_addr = bus.pc_in;

    always_comb begin
        bus.pc_load = 1'b0;
        bus.pc_new  = bus.pc_in;
        if (bus.redirect_valid) begin
            bus.pc_load = 1'b1;
            bus.pc_new  = bus.redirect_pc;
        end else if (stall) begin
            bus.pc_load = 1'b1;
        end
    end

    // Outputs are gated by count so stale array contents never leak after reset or flush.
    always_comb begin
        bus.instr_valid = q_valid;
        bus.instr_data  = q_valid ? head.instr : '0;
        bus.instr_pc    = q_valid ? head.pc : '0;
        if (bypass) begin
            bus.instr_valid = 1'b1;
            bus.instr_data  = bus.rom_data;
            bus.instr_pc    = inflight_pc_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= {inflight_pc_reg, bus.rom_data};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg <= bus.pc_in;
            end
            // A head handshake in the redirect cycle is still delivered; only the remainder is dropped.
            if (bus.redirect_valid) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
                if (push && !pop) begin
                    count_reg <= count_reg + CNT_W'(1);
                end else if (!push && pop) begin
                    count_reg <= count_reg - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: models program_counter and a ROM returning ~addr, and checks the delivered
// instruction stream against the expected program order (sequential from each reset/redirect target).
module tb_fetch_unit;
    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic        mon_en = 1'b0;
    int          total  = 0;
    int          bad    = 0;
    logic [15:0] seg_q [$];
    logic [15:0] pc_reg;

    fetch_unit_if #(.INSTR_W(16)) bus ();

    fetch_unit #(.DEPTH(DEPTH), .INSTR_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // program_counter and synchronous ROM models
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_reg <= '0;
        else        pc_reg <= bus.pc_load ? bus.pc_new : pc_reg + 16'd1;
    end
    assign bus.pc_in = pc_reg;

    always_ff @(posedge clk) begin
        bus.rom_data <= ~bus.rom_addr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_segment(inout logic [15:0] p);
        chk("seg_avail", 32'(seg_q.size() != 0), 32'd1);
        if (seg_q.size() != 0) p = seg_q.pop_front();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        seg_q.push_back(16'h0000);
        bus.redirect_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr_data",  32'(bus.instr_data),  32'd0);
        chk("rst_instr_pc",    32'(bus.instr_pc),    32'd0);
        chk("rst_pc_load",     32'(bus.pc_load),     32'd0);
        chk("rst_pc_new",      32'(bus.pc_new),      32'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Called at the start of a cycle; reports how many cycles later instr_valid first rises.
    task automatic first_valid(input string name, input int exp_lat, input logic [15:0] exp_pc);
        int lat;
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_pc"},  32'(bus.instr_pc), 32'(exp_pc));
    endtask

    // Scoreboard monitor: expected stream restarts at each popped segment start.
    initial begin : monitor
        logic [15:0] exp_pc;
        logic [15:0] exp_data;
        logic        in_rst;
        exp_pc = '0;
        in_rst = 1'b0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (!in_rst) next_segment(exp_pc);
                in_rst = 1'b1;
                chk("rst_hold_valid", 32'(bus.instr_valid), 32'd0);
            end else begin
                in_rst = 1'b0;
                chk("rom_addr", 32'(bus.rom_addr), 32'(pc_reg));
                if (bus.redirect_valid) begin
                    chk("redir_pc_load", 32'(bus.pc_load), 32'd1);
                    chk("redir_pc_new",  32'(bus.pc_new),  32'(bus.redirect_pc));
                end
                if (bus.instr_valid) begin
                    exp_data = ~exp_pc;
                    chk("head_pc",   32'(bus.instr_pc),   32'(exp_pc));
                    chk("head_data", 32'(bus.instr_data), 32'(exp_data));
                    if (bus.instr_ready) begin
                        $display("xfer pc=%h data=%h", bus.instr_pc, bus.instr_data);
                        exp_pc = exp_pc + 16'd1;
                    end
                end
                if (bus.redirect_valid) next_segment(exp_pc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          r;
        logic [15:0] tgt;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        rst_n = 1'b1;
        #2;
        mon_en = 1'b1;

        // sequential fetch with decode always ready
        do_reset();
        first_valid("seq_first", LAT, 16'h0000);
        repeat (12) step();

        // decode stalled from reset: queue fills, PC held at 0x0004, then drains in order
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (6) step();
        bus.instr_ready = 1'b1;
        @(negedge clk);
        chk("stall_pc_load", 32'(bus.pc_load), 32'd1);
        chk("stall_pc_new",  32'(bus.pc_new),  32'h0004);
        chk("stall_pc_in",   32'(bus.pc_in),   32'h0004);
        chk("full_head_pc",  32'(bus.instr_pc), 32'h0000);

        // redirect coinciding with handshake of pc 0x0005
        repeat (5) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0200;
        seg_q.push_back(16'h0200);
        @(negedge clk);
        chk("hs_valid", 32'(bus.instr_valid), 32'd1);
        chk("hs_pc",    32'(bus.instr_pc),    32'h0005);
        step();
        bus.redirect_valid = 1'b0;
        first_valid("redir_hs", LAT, 16'h0200);

        // redirect while the queue is full
        step();
        bus.instr_ready = 1'b0;
        repeat (8) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0100;
        seg_q.push_back(16'h0100);
        @(negedge clk);
        chk("full_valid",      32'(bus.instr_valid), 32'd1);
        chk("full_redir_load", 32'(bus.pc_load),     32'd1);
        chk("full_redir_new",  32'(bus.pc_new),      32'h0100);
        step();
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b1;
        first_valid("redir_full", LAT, 16'h0100);
        repeat (6) step();

        // reset with three words queued
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (4) step();
        @(negedge clk);
        chk("mid_valid", 32'(bus.instr_valid), 32'd1);
        chk("mid_pc",    32'(bus.instr_pc),    32'h0000);
        #1;
        do_reset();
        bus.instr_ready = 1'b1;
        first_valid("rst_mid", LAT, 16'h0000);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            step();
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset();
            end else begin
                bus.instr_ready = ($urandom_range(0, 3) != 0);
                if (r < 10) begin
                    tgt = 16'($urandom);
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = tgt;
                    seg_q.push_back(tgt);
                end else begin
                    bus.redirect_valid = 1'b0;
                end
            end
        end
        step();
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b1;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
